fpu_float_to_int: RTL and testbench
===================================

# fpu_float_to_int

- Pipelined, parametrised IEEE-754-style float-to-integer converter for the FPU datapath.
- Converts a packed float to a signed or unsigned two's-complement integer.
- Rounding mode is selected per transaction; results saturate on overflow and carry exception flags.
- Uses a valid/ready handshake on both sides, so it sits between the FPU operand issue logic and the integer writeback path.

## Interface
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa (fraction) width.
- INT_W, 32, integer result width; INT_W >= 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  1+EXP_W+MAN_W  float: {sign, exponent, fraction}.
- in_signed  in  1  1 = signed result, 0 = unsigned result.
- in_rmode  in  2  rounding mode: 00 RNE (ties to even), 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  INT_W  integer result.
- out_flags  out  3  {invalid, overflow, inexact}.

## Operation
- **Transfer rules.**
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - in_signed and in_rmode are sampled with in_data and travel with that transaction.
- **Stage S1, classify.**
  - Compute e = E - bias.
  - Classes: zero/denormal (E=0), normal, Inf (E all ones, F=0), NaN (E all ones, F≠0).
  - Significand = {1,F} for normals; denormals are treated as magnitude < 1.
- **Stage S2, shift and round.**
  - If e < 0: the integer part is 0 and all significand bits feed guard/sticky.
  - If e >= INT_W: mark out of range; do not shift.
  - Otherwise: shift {1,F} so the integer part occupies INT_W+1 bits, keeping a guard bit and an OR-reduced sticky bit.
  - Round the magnitude by mode and sign:
    - RNE: increment if guard & (sticky | lsb).
    - RTZ: never increment.
    - RDN: increment if negative & (guard|sticky).
    - RUP: increment if positive & (guard|sticky).
  - inexact_raw = guard | sticky.
- **Stage S3, range check, negate, saturate, register.**
  - Signed range: magnitude <= 2^(INT_W-1)-1 if positive, <= 2^(INT_W-1) if negative.
  - Unsigned range: magnitude <= 2^INT_W-1 if positive.
  - Unsigned and negative: a rounded magnitude of 0 is legal (result 0); any nonzero rounded magnitude is overflow.
  - NaN: out_data = max positive (signed 2^(INT_W-1)-1, unsigned 2^INT_W-1); flags = 100.
  - Inf or out of range: saturate by sign.
    - Positive: max positive.
    - Negative: signed min 2^(INT_W-1) pattern, unsigned 0.
    - flags = 010.
  - In range: out_data = sign ? -magnitude : magnitude; flags = {0,0,inexact_raw}.
  - Flags are mutually exclusive; invalid has priority over overflow, which has priority over inexact.
  - Zero of either sign gives 0 with flags 000.

## Timing
- **Reset.** Reset clears all stage valid bits immediately: out_valid=0, out_data=0, out_flags=000. in_ready=1 while rst is high and after it is released.
- **Latency.** 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- **Stall.**
  - in_ready = ~out_valid | out_ready (combinational).
  - When out_valid & ~out_ready, all three stages hold. out_data and out_flags stay stable until the transfer.
  - Bubbles are not collapsed during a stall.
- **Simultaneous events.** With out_ready=1 and out_valid=1, a new input is accepted in the same cycle as the output retires.
- **Reset mid-operation.** In-flight transactions are discarded. No output appears for them after reset deasserts.
- **Timing rules.**
  - No combinational path from in_data to out_data.
  - out_valid depends only on registers.

## Test plan
- **Rounding modes.**
  - 0x40200000 (2.5), signed, RNE -> 0x00000002, flags 001.
  - Same input, RUP -> 0x00000003, flags 001.
  - 0xC0200000 (-2.5), RDN -> 0xFFFFFFFD, flags 001.
  - 0x3FC00000 (1.5), RTZ -> 1, flags 001.
- **Range edges.**
  - 0x4F000000 (2^31), signed -> 0x7FFFFFFF, flags 010; unsigned -> 0x80000000, flags 000.
  - 0xCF000000 (-2^31), signed -> 0x80000000, flags 000.
- **Specials.**
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, flags 100.
  - 0xFF800000 (-Inf), signed -> 0x80000000, flags 010.
  - 0x80000000 (-0) -> 0, flags 000.
- **Unsigned and tiny values.**
  - 0xBE99999A (-0.3), unsigned, RNE -> 0, flags 001.
  - 0xBF800000 (-1.0), unsigned -> 0, flags 010.
  - 0x00000001 (denormal), RUP -> 1, flags 001.
- **Backpressure.**
  - Stream 8 back-to-back inputs (1.0 .. 8.0); hold out_ready=0 for 4 cycles mid-stream.
  - Required: results 1..8 in order, no loss or duplication, out_data stable while stalled, in_ready=0 during the stall.
- **Reset.** Pulse rst with 2 transactions in flight -> out_valid=0 immediately and no stale output afterward; the next input yields its result 3 cycles after acceptance.

Source files
------------

// File: rtl/fpu_float_to_int.sv
// Three-stage float-to-integer converter: classify, shift/round, range-check/saturate.
// All stages advance together on a single enable, so a stalled output freezes the whole pipe.
module fpu_float_to_int #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_data,
    input  logic                 in_signed,
    input  logic [1:0]           in_rmode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_W-1:0]     out_data,
    output logic [2:0]           out_flags
);
    // Unbiased exponent width: wide enough for the full exponent range and for INT_W as a signed value.
    localparam int EW  = (EXP_W + 2 > $clog2(INT_W + 1) + 2) ? EXP_W + 2 : $clog2(INT_W + 1) + 2;
    localparam int FB  = MAN_W + 1;
    localparam int AW  = INT_W + 1 + FB;
    localparam int SHW = $clog2(INT_W + 1);

    localparam logic signed [EW-1:0] BIAS    = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] INT_W_E = EW'(INT_W);
    localparam logic [INT_W:0]   SMIN_MAG = {2'b01, {(INT_W-1){1'b0}}};
    localparam logic [INT_W:0]   SMAX_MAG = SMIN_MAG - (INT_W+1)'(1);
    localparam logic [INT_W-1:0] MAX_S    = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MIN_S    = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] MAX_U    = '1;

    logic adv;

    // Stage 1 registers
    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic signed [EW-1:0] s1_exp_q;
    logic [MAN_W-1:0]     s1_frac_q;
    logic                 s1_small_q;
    logic                 s1_nan_q;
    logic                 s1_inf_q;
    logic                 s1_signed_q;
    logic [1:0]           s1_rmode_q;

    // Stage 2 registers
    logic                 s2_valid_q;
    logic                 s2_sign_q;
    logic                 s2_signed_q;
    logic                 s2_nan_q;
    logic                 s2_big_q;
    logic [INT_W:0]       s2_mag_q;
    logic                 s2_inexact_q;

    // Output registers
    logic                 out_valid_q;
    logic [INT_W-1:0]     out_data_q;
    logic [2:0]           out_flags_q;

    logic [EXP_W-1:0]     in_exp;
    logic [MAN_W-1:0]     in_frac;
    logic signed [EW-1:0] exp_d;
    logic                 in_small;
    logic                 in_special;

    logic [AW-1:0]        acc;
    logic [SHW-1:0]       sh;
    logic [INT_W:0]       int_part;
    logic                 guard;
    logic                 sticky;
    logic                 oor;
    logic                 inc;
    logic [INT_W:0]       mag_d;

    logic                 range_ovf;
    logic [INT_W-1:0]     mag_lo;
    logic [INT_W-1:0]     max_pos;
    logic [INT_W-1:0]     sat_neg;
    logic [INT_W-1:0]     out_data_d;
    logic [2:0]           out_flags_d;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

    assign in_exp     = in_data[EXP_W+MAN_W-1:MAN_W];
    assign in_frac    = in_data[MAN_W-1:0];
    assign in_small   = (in_exp == '0);
    assign in_special = &in_exp;
    assign exp_d      = $signed({{(EW-EXP_W){1'b0}}, in_exp}) - BIAS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
            s1_small_q  <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_rmode_q  <= 2'b00;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= in_data[EXP_W+MAN_W];
                s1_exp_q    <= exp_d;
                s1_frac_q   <= in_frac;
                s1_small_q  <= in_small;
                s1_nan_q    <= in_special & (in_frac != '0);
                s1_inf_q    <= in_special & (in_frac == '0);
                s1_signed_q <= in_signed;
                s1_rmode_q  <= in_rmode;
            end
        end
    end

    // The accumulator carries FB fraction bits; shifting {1,F} left by e+1 lines
    // the binary point up at bit FB, leaving guard at FB-1 and sticky below it.
    always_comb begin
        acc      = '0;
        sh       = SHW'(s1_exp_q) + SHW'(1);
        int_part = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        oor      = 1'b0;
        if (s1_small_q) begin
            sticky = |s1_frac_q;
        end else if (s1_exp_q[EW-1]) begin
            guard  = &s1_exp_q;
            sticky = (&s1_exp_q) ? (|s1_frac_q) : 1'b1;
        end else if (s1_exp_q >= INT_W_E) begin
            oor = 1'b1;
        end else begin
            acc      = AW'({1'b1, s1_frac_q}) << sh;
            int_part = acc[AW-1:FB];
            guard    = acc[FB-1];
            sticky   = |acc[FB-2:0];
        end

        case (s1_rmode_q)
            2'b00:   inc = guard & (sticky | int_part[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = s1_sign_q & (guard | sticky);
            default: inc = ~s1_sign_q & (guard | sticky);
        endcase
        mag_d = int_part + {{INT_W{1'b0}}, inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_signed_q  <= 1'b0;
            s2_nan_q     <= 1'b0;
            s2_big_q     <= 1'b0;
            s2_mag_q     <= '0;
            s2_inexact_q <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q    <= s1_sign_q;
                s2_signed_q  <= s1_signed_q;
                s2_nan_q     <= s1_nan_q;
                s2_big_q     <= s1_inf_q | oor;
                s2_mag_q     <= mag_d;
                s2_inexact_q <= guard | sticky;
            end
        end
    end

    // Negative values in unsigned mode are only legal when they round to zero.
    always_comb begin
        mag_lo = s2_mag_q[INT_W-1:0];
        if (s2_signed_q) begin
            range_ovf = s2_sign_q ? (s2_mag_q > SMIN_MAG) : (s2_mag_q > SMAX_MAG);
        end else begin
            range_ovf = s2_sign_q ? (s2_mag_q != '0) : s2_mag_q[INT_W];
        end
        max_pos = s2_signed_q ? MAX_S : MAX_U;
        sat_neg = s2_signed_q ? MIN_S : '0;

        if (s2_nan_q) begin
            out_data_d  = max_pos;
            out_flags_d = 3'b100;
        end else if (s2_big_q | range_ovf) begin
            out_data_d  = s2_sign_q ? sat_neg : max_pos;
            out_flags_d = 3'b010;
        end else begin
            out_data_d  = s2_sign_q ? -mag_lo : mag_lo;
            out_flags_d = {2'b00, s2_inexact_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= 3'b000;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q  <= out_data_d;
                out_flags_q <= out_flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fpu_float_to_int.sv
// Scoreboard bench: expected results queued on input acceptance, compared on output transfer.
module tb_fpu_float_to_int;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int INT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [EXP_W+MAN_W:0] in_data;
    logic                 in_signed;
    logic [1:0]           in_rmode;
    logic                 out_valid;
    logic                 out_ready;
    logic [INT_W-1:0]     out_data;
    logic [2:0]           out_flags;

    fpu_float_to_int #(.EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_rmode  (in_rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        int          cyc;
        bit          lat;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] cur_data;
    logic [2:0]  cur_flags;
    string       cur_tag;
    bit          cur_lat;
    bit          hold_pend;
    logic [31:0] hold_data;
    logic [2:0]  hold_flags;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hold_data);
                check("stall_flags", out_flags, hold_flags);
            end
            hold_pend = 1'b0;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                hold_pend  = 1'b1;
                hold_data  = out_data;
                hold_flags = out_flags;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn %s: data=0x%08h flags=%03b", e.tag, out_data, out_flags);
                    check({e.tag, "_data"}, out_data, e.data);
                    check({e.tag, "_flags"}, out_flags, e.flags);
                    if (e.lat) check("latency", cyc - e.cyc, 3);
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back('{cur_data, cur_flags, cyc, cur_lat, cur_tag});
        end
    end

    task automatic send(input string tag, input logic [31:0] f, input bit sgn,
                        input logic [1:0] rm, input logic [31:0] d, input logic [2:0] fl);
        int n = 0;
        bit acc = 1'b0;
        in_valid  = 1'b1;
        in_data   = f;
        in_signed = sgn;
        in_rmode  = rm;
        cur_data  = d;
        cur_flags = fl;
        cur_tag   = tag;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check({tag, "_accept_timeout"}, in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_rmode  = 2'b00;
        out_ready = 1'b1;
        cur_lat   = 1'b0;
        cur_data  = '0;
        cur_flags = '0;
        cur_tag   = "";
        hold_pend = 1'b0;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1);

        // Directed vectors, back-to-back with out_ready held high.
        send("rne_2p5",    32'h40200000, 1, 2'b00, 32'h00000002, 3'b001);
        send("rup_2p5",    32'h40200000, 1, 2'b11, 32'h00000003, 3'b001);
        send("rdn_m2p5",   32'hC0200000, 1, 2'b10, 32'hFFFFFFFD, 3'b001);
        send("rtz_m2p5",   32'hC0200000, 1, 2'b01, 32'hFFFFFFFE, 3'b001);
        send("rtz_1p5",    32'h3FC00000, 1, 2'b01, 32'h00000001, 3'b001);
        send("rne_1p5",    32'h3FC00000, 1, 2'b00, 32'h00000002, 3'b001);
        send("rne_3p5",    32'h40600000, 1, 2'b00, 32'h00000004, 3'b001);
        send("rup_m1p5",   32'hBFC00000, 1, 2'b11, 32'hFFFFFFFF, 3'b001);
        send("rne_0p5",    32'h3F000000, 1, 2'b00, 32'h00000000, 3'b001);
        send("s_2p31",     32'h4F000000, 1, 2'b00, 32'h7FFFFFFF, 3'b010);
        send("u_2p31",     32'h4F000000, 0, 2'b00, 32'h80000000, 3'b000);
        send("s_m2p31",    32'hCF000000, 1, 2'b00, 32'h80000000, 3'b000);
        send("u_2p32",     32'h4F800000, 0, 2'b00, 32'hFFFFFFFF, 3'b010);
        send("s_nan",      32'h7FC00000, 1, 2'b00, 32'h7FFFFFFF, 3'b100);
        send("u_nan",      32'h7FC00000, 0, 2'b00, 32'hFFFFFFFF, 3'b100);
        send("s_minf",     32'hFF800000, 1, 2'b00, 32'h80000000, 3'b010);
        send("u_pinf",     32'h7F800000, 0, 2'b01, 32'hFFFFFFFF, 3'b010);
        send("neg_zero",   32'h80000000, 1, 2'b00, 32'h00000000, 3'b000);
        send("u_neg_zero", 32'h80000000, 0, 2'b10, 32'h00000000, 3'b000);
        send("u_m0p3",     32'hBE99999A, 0, 2'b00, 32'h00000000, 3'b001);
        send("u_m1",       32'hBF800000, 0, 2'b00, 32'h00000000, 3'b010);
        send("u_m0p3_rdn", 32'hBE99999A, 0, 2'b10, 32'h00000000, 3'b010);
        send("denorm_rup", 32'h00000001, 1, 2'b11, 32'h00000001, 3'b001);
        send("denorm_rne", 32'h00000001, 1, 2'b00, 32'h00000000, 3'b001);
        drain("directed");

        // Stream 1.0 .. 8.0 with a four-cycle output stall mid-stream.
        fork
            begin
                send("stream_1", 32'h3F800000, 1, 2'b00, 32'd1, 3'b000);
                send("stream_2", 32'h40000000, 1, 2'b00, 32'd2, 3'b000);
                send("stream_3", 32'h40400000, 1, 2'b00, 32'd3, 3'b000);
                send("stream_4", 32'h40800000, 1, 2'b00, 32'd4, 3'b000);
                send("stream_5", 32'h40A00000, 1, 2'b00, 32'd5, 3'b000);
                send("stream_6", 32'h40C00000, 1, 2'b00, 32'd6, 3'b000);
                send("stream_7", 32'h40E00000, 1, 2'b00, 32'd7, 3'b000);
                send("stream_8", 32'h41000000, 1, 2'b00, 32'd8, 3'b000);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stream");

        // Reset with two transactions in flight, the first one stalled at the output.
        out_ready = 1'b0;
        send("flush_a", 32'h3F800000, 1, 2'b00, 32'd1, 3'b000);
        send("flush_b", 32'h40000000, 1, 2'b00, 32'd2, 3'b000);
        @(posedge clk);
        #2;
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_flags", out_flags, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_output", out_valid, 0);
        cur_lat = 1'b1;
        send("after_rst", 32'h40400000, 1, 2'b00, 32'd3, 3'b000);
        cur_lat = 1'b0;
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
